// File: rtl/key_debounce_repeat_pkg.sv
// Shared constants for the push-key front end: key count, default 50 MHz timing
// and the per-channel FSM state encodings.
package key_debounce_repeat_pkg;

  localparam int NUM_KEYS = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  typedef logic [1:0] key_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESS_F = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_REL_F   = 2'd3;

endpackage

// File: rtl/key_debounce_repeat_if.sv
// Key bundle between the board pins / key consumer and the debounce front end.
interface key_debounce_repeat_if;
  import key_debounce_repeat_pkg::*;

  logic [NUM_KEYS-1:0] Key_In;
  logic [NUM_KEYS-1:0] Key_Out;
  logic [NUM_KEYS-1:0] Key_Held;

  modport master (output Key_In, input Key_Out, input Key_Held);
  modport slave  (input Key_In, output Key_Out, output Key_Held);

endinterface

// File: rtl/key_debounce_repeat_channel.sv
// One key: 2-FF synchroniser, press/release debounce FSM and auto-repeat timer.
module key_debounce_repeat_channel
  import key_debounce_repeat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pulse,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_FULL   = CW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RPT_ONE    = RW'(1);
  localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("key_debounce_repeat_channel: need DEBOUNCE_CYCLES>=2 and 1<=REPEAT_PERIOD<=REPEAT_DELAY");
  end

  logic [1:0]    sync;
  logic          s;
  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] rpt, rpt_nxt;
  logic          pulse_nxt, held_nxt;

  // Preset to 1 so a key held through reset looks released until it is re-sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_raw};
  end

  assign s = sync[1];

  // cnt holds the number of consecutive stable samples already seen; a level is
  // accepted on the edge that takes the DEBOUNCE_CYCLES-th sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rpt_nxt   = rpt;
    pulse_nxt = 1'b0;
    held_nxt  = held;
    case (state)
      ST_IDLE: begin
        if (!s) begin
          state_nxt = ST_PRESS_F;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_PRESS_F: begin
        if (s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt >= DEB_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = DEB_FULL;
          rpt_nxt   = '0;
          pulse_nxt = 1'b1;
          held_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (s) begin
          state_nxt = ST_REL_F;
          cnt_nxt   = CNT_ONE;
        end else if (REPEAT_EN != 0) begin
          if (rpt >= RPT_LAST) begin
            rpt_nxt   = RPT_RELOAD;
            pulse_nxt = 1'b1;
          end else begin
            rpt_nxt = rpt + RPT_ONE;
          end
        end
      end
      ST_REL_F: begin
        // Repeat timer is frozen here and resumes if the release turns out to be a bounce.
        if (!s) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt >= DEB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          held_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        held_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rpt   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rpt   <= rpt_nxt;
      pulse <= pulse_nxt;
      held  <= held_nxt;
    end
  end

endmodule

// File: rtl/key_debounce_repeat.sv
// 4-key debounce / auto-repeat front end: one independent channel per key pin,
// outputs concatenated into the pulse and held-level buses.
module key_debounce_repeat
  import key_debounce_repeat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  key_debounce_repeat_if.slave keys
);

  logic [NUM_KEYS-1:0] pulse;
  logic [NUM_KEYS-1:0] held;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_repeat_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RST_N),
      .key_raw (keys.Key_In[i]),
      .pulse   (pulse[i]),
      .held    (held[i])
    );
  end

  assign keys.Key_Out  = pulse;
  assign keys.Key_Held = held;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench: one DUT with auto-repeat, one without, same key stimulus;
// expected pulses are queued when keys are driven and matched cycle by cycle.
module tb_key_debounce_repeat;

  localparam int D   = 8;
  localparam int RD  = 32;
  localparam int RP  = 16;
  localparam int LAT = D + 2;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] keys;
  int         cyc;
  int         total;
  int         bad;
  int         t0;
  int         t1;
  ev_t        q_r[$];
  ev_t        q_n[$];

  key_debounce_repeat_if kif_r ();
  key_debounce_repeat_if kif_n ();

  assign kif_r.Key_In = keys;
  assign kif_n.Key_In = keys;

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut_r (
    .CLK   (clk),
    .RST_N (rst_n),
    .keys  (kif_r)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (0),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut_n (
    .CLK   (clk),
    .RST_N (rst_n),
    .keys  (kif_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_both(input int at, input logic [3:0] v);
    ev_t e;
    e.cyc = at;
    e.val = v;
    q_r.push_back(e);
    q_n.push_back(e);
  endtask

  task automatic expect_rpt(input int at, input logic [3:0] v);
    ev_t e;
    e.cyc = at;
    e.val = v;
    q_r.push_back(e);
  endtask

  // One clock edge, then compare Key_Out of both DUTs against the scoreboard.
  task automatic tick();
    logic       due;
    logic [3:0] want;
    ev_t        e;
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n) begin
      due  = (q_r.size() > 0) && (q_r[0].cyc == cyc);
      want = 4'b0000;
      if (due) begin
        e    = q_r.pop_front();
        want = e.val;
      end
      if (due || kif_r.Key_Out !== 4'b0000)
        chk($sformatf("pulse_rpt@%0d", cyc), 32'(kif_r.Key_Out), 32'(want));

      due  = (q_n.size() > 0) && (q_n[0].cyc == cyc);
      want = 4'b0000;
      if (due) begin
        e    = q_n.pop_front();
        want = e.val;
      end
      if (due || kif_n.Key_Out !== 4'b0000)
        chk($sformatf("pulse_norpt@%0d", cyc), 32'(kif_n.Key_Out), 32'(want));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_held(input string tag, input logic [3:0] mask, input logic [3:0] exp);
    chk({tag, "_rpt"},   32'(kif_r.Key_Held & mask), 32'(exp));
    chk({tag, "_norpt"}, 32'(kif_n.Key_Held & mask), 32'(exp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    keys  = 4'hF;
    rst_n = 1'b0;
    ticks(3);

    // Reset with every key pressed: outputs stay quiet.
    keys = 4'h0;
    ticks(2);
    chk("reset_out_rpt",    32'(kif_r.Key_Out),  32'h0);
    chk("reset_held_rpt",   32'(kif_r.Key_Held), 32'h0);
    chk("reset_out_norpt",  32'(kif_n.Key_Out),  32'h0);
    chk("reset_held_norpt", 32'(kif_n.Key_Held), 32'h0);

    // Release reset with keys still low: full debounce before the first pulse.
    rst_n = 1'b1;
    t0 = cyc;
    expect_both(t0 + LAT, 4'hF);
    ticks(LAT - 1);
    chk_held("held_before_debounce", 4'hF, 4'h0);
    tick();
    chk_held("held_after_debounce", 4'hF, 4'hF);
    keys = 4'hF;
    ticks(LAT - 1);
    chk_held("held_release_wait", 4'hF, 4'hF);
    tick();
    chk_held("held_released", 4'hF, 4'h0);
    ticks(5);

    // Clean press of key0, single pulse, no pulse on release.
    keys = 4'hE;
    t0 = cyc;
    expect_both(t0 + LAT, 4'h1);
    ticks(20);
    keys = 4'hF;
    ticks(LAT - 1);
    chk_held("key0_held_until_release", 4'h1, 4'h1);
    tick();
    chk_held("key0_released", 4'h1, 4'h0);
    ticks(5);

    // Bouncing key1: never accepted.
    for (int k = 0; k < 10; k++) begin
      keys = (k % 2 == 0) ? 4'hD : 4'hF;
      ticks(3);
    end
    keys = 4'hF;
    ticks(12);
    chk_held("key1_bounce_held", 4'h2, 4'h0);

    // Key2 held long: first pulse plus repeats on the repeat-enabled DUT only.
    keys = 4'hB;
    t0 = cyc;
    expect_both(t0 + LAT, 4'h4);
    expect_rpt(t0 + LAT + RD,          4'h4);
    expect_rpt(t0 + LAT + RD + RP,     4'h4);
    expect_rpt(t0 + LAT + RD + 2 * RP, 4'h4);
    expect_rpt(t0 + LAT + RD + 3 * RP, 4'h4);
    expect_rpt(t0 + LAT + RD + 4 * RP, 4'h4);
    ticks(110);
    chk_held("key2_held", 4'h4, 4'h4);
    keys = 4'hF;
    ticks(20);
    chk_held("key2_released", 4'h4, 4'h0);

    // Key0 and key3 together: both bits in one pulse.
    keys = 4'h6;
    t0 = cyc;
    expect_both(t0 + LAT, 4'h9);
    ticks(15);
    chk_held("key03_held", 4'hF, 4'h9);
    keys = 4'hF;
    ticks(15);
    chk_held("key03_released", 4'hF, 4'h0);

    // Key1 release with a 2-cycle low glitch during release debounce.
    keys = 4'hD;
    t0 = cyc;
    expect_both(t0 + LAT, 4'h2);
    ticks(14);
    keys = 4'hF;
    t1 = cyc;
    ticks(5);
    keys = 4'hD;
    ticks(2);
    keys = 4'hF;
    ticks(5);
    chk_held("key1_relbounce_held_a", 4'h2, 4'h2);
    ticks(4);
    chk_held("key1_relbounce_held_b", 4'h2, 4'h2);
    tick();
    chk_held("key1_relbounce_released", 4'h2, 4'h0);
    ticks(5);

    chk("queue_drained_rpt",   32'(q_r.size()), 32'd0);
    chk("queue_drained_norpt", 32'(q_n.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
